// File: rtl/rv_fetch_pkg.sv
// Shared types for the prefetching fetch unit.
//   FETCH_PC_W    : width of a word address (byte address bits [31:2])
//   fetch_entry_t : one prefetched instruction with its bus-error flag and word PC
package rv_fetch_pkg;

  localparam int unsigned FETCH_PC_W = 30;

  typedef struct packed {
    logic [31:0]           inst;
    logic                  err;
    logic [FETCH_PC_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/rv_fetch_fifo.sv
// In-order synchronous FIFO of fetch_entry_t for the prefetch buffer.
// The head entry is read straight from the storage flops, so a push becomes
// visible on vld_o/head_o the cycle after it is written.
//   clk_i   in   1      clock
//   rst_ni  in   1      synchronous reset, active-low (storage cleared too)
//   flush_i in   1      drop every entry; overrides push/pop
//   push_i  in   1      write data_i at the tail
//   data_i  in   entry  entry to write
//   pop_i   in   1      retire the head entry
//   vld_o   out  1      head entry valid
//   head_o  out  entry  head entry
//   cnt_o   out  CW     number of valid entries
module rv_fetch_fifo
  import rv_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                flush_i,
  input  logic                                push_i,
  input  fetch_entry_t                        data_i,
  input  logic                                pop_i,
  output logic                                vld_o,
  output fetch_entry_t                        head_o,
  output logic [$clog2(DEPTH+1)-1:0]          cnt_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + PW'(1);
      if (pop_i)  rd_d = rd_q + PW'(1);
      cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (push_i && !flush_i) mem_q[wr_q] <= data_i;
    end
  end

  assign vld_o  = (cnt_q != '0);
  assign head_o = mem_q[rd_q];
  assign cnt_o  = cnt_q;

  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && !flush_i && cnt_q == CW'(DEPTH)));
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(pop_i && !flush_i && cnt_q == '0));

endmodule

// File: rtl/rv_fetch_pf.sv
// Prefetching fetch unit: request-PC generator, pipelined instruction-bus
// master and in-order prefetch FIFO presenting a valid/ready stream to decode.
// Optional feature macro: RV_FETCH_PERF_EN (adds o_perf_fetched/o_perf_flushed).
//   i_clk/i_reset_n          clock, synchronous active-low reset
//   i_pc_sel/i_pc_target     one-cycle redirect strobe and word target
//   o_bus_req/o_bus_addr     read request and word address
//   i_bus_gnt                request accepted
//   i_bus_ack/i_bus_rdata    in-order read response and data
//   i_bus_err                response error, qualified by i_bus_ack
//   o_inst_vld/i_inst_rdy    head handshake towards decode
//   o_inst/o_inst_err/o_pc   head instruction, error flag, word PC
//   o_pc_p4                  o_pc + 1 (word), wraps
module rv_fetch_pf
  import rv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned MAX_OUTST  = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_pc_sel,
  input  logic [FETCH_PC_W-1:0] i_pc_target,
  output logic                  o_bus_req,
  output logic [FETCH_PC_W-1:0] o_bus_addr,
  input  logic                  i_bus_gnt,
  input  logic                  i_bus_ack,
  input  logic [31:0]           i_bus_rdata,
  input  logic                  i_bus_err,
  output logic                  o_inst_vld,
  input  logic                  i_inst_rdy,
  output logic [31:0]           o_inst,
  output logic                  o_inst_err,
  output logic [FETCH_PC_W-1:0] o_pc,
  output logic [FETCH_PC_W-1:0] o_pc_p4
`ifdef RV_FETCH_PERF_EN
  ,
  output logic [31:0]           o_perf_fetched,
  output logic [31:0]           o_perf_flushed
`endif
);

  localparam int unsigned OW = $clog2(MAX_OUTST + 1);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [FETCH_PC_W-1:0] RESET_PC = RESET_ADDR[31:2];

  logic [FETCH_PC_W-1:0] req_pc_q, req_pc_d;
  logic [FETCH_PC_W-1:0] rsp_pc_q, rsp_pc_d;
  // outst_q counts every read in flight, stale ones included; discard_q is
  // the stale subset still to be dropped (always <= outst_q).
  logic [OW-1:0]         outst_q, outst_d;
  logic [OW-1:0]         discard_q, discard_d;
  logic [CW-1:0]         fifo_cnt;
  logic                  fire, push, pop, head_vld;
  fetch_entry_t          push_entry, head;

  // Credits include stale reads, so an ack can never find the FIFO full.
  assign o_bus_req  = i_reset_n && !i_pc_sel
                    && (32'(outst_q) < MAX_OUTST)
                    && ((32'(fifo_cnt) + 32'(outst_q)) < DEPTH);
  assign o_bus_addr = req_pc_q;
  assign fire       = o_bus_req && i_bus_gnt;

  assign push       = i_bus_ack && !i_pc_sel && (discard_q == '0);
  assign pop        = head_vld && i_inst_rdy && !i_pc_sel;
  assign push_entry = '{inst: i_bus_rdata, err: i_bus_err, pc: rsp_pc_q};

  always_comb begin
    req_pc_d  = req_pc_q;
    rsp_pc_d  = rsp_pc_q;
    outst_d   = outst_q;
    discard_d = discard_q;
    if (i_pc_sel) begin
      req_pc_d  = i_pc_target;
      rsp_pc_d  = i_pc_target;
      // Everything still in flight after this cycle is stale; an ack in
      // this cycle is dropped. No request can fire here.
      outst_d   = outst_q - OW'(i_bus_ack);
      discard_d = outst_d;
    end else begin
      if (fire) req_pc_d = req_pc_q + FETCH_PC_W'(1);
      outst_d = outst_q + OW'(fire) - OW'(i_bus_ack);
      if (i_bus_ack) begin
        if (discard_q != '0) discard_d = discard_q - OW'(1);
        else                 rsp_pc_d  = rsp_pc_q + FETCH_PC_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      req_pc_q  <= RESET_PC;
      rsp_pc_q  <= RESET_PC;
      outst_q   <= '0;
      discard_q <= '0;
    end else begin
      req_pc_q  <= req_pc_d;
      rsp_pc_q  <= rsp_pc_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
    end
  end

  rv_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (i_clk),
    .rst_ni  (i_reset_n),
    .flush_i (i_pc_sel),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .vld_o   (head_vld),
    .head_o  (head),
    .cnt_o   (fifo_cnt)
  );

  assign o_inst_vld = head_vld;
  assign o_inst     = head.inst;
  assign o_inst_err = head.err;
  assign o_pc       = head.pc;
  assign o_pc_p4    = head.pc + FETCH_PC_W'(1);

`ifdef RV_FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_flushed_q, perf_flushed_d;
  logic        ack_dropped;

  assign ack_dropped = i_bus_ack && (i_pc_sel || (discard_q != '0));

  always_comb begin
    perf_fetched_d = perf_fetched_q + 32'(push);
    perf_flushed_d = perf_flushed_q + 32'(ack_dropped)
                   + (i_pc_sel ? 32'(fifo_cnt) : 32'd0);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      perf_fetched_q <= '0;
      perf_flushed_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_flushed_q <= perf_flushed_d;
    end
  end

  assign o_perf_fetched = perf_fetched_q;
  assign o_perf_flushed = perf_flushed_q;
`endif

  a_no_ack_idle: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    i_bus_ack |-> (outst_q != '0));

endmodule
